imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter MAX_WORDS, default 256: instruction-memory capacity in 32-bit words.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of the first word written.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 byte_valid  input  1  the source is presenting byte_data.
REQ-006 byte_data  input  8  serial image byte.
REQ-007 byte_ready  output  1  the loader accepts a byte; transfer occurs when byte_valid && byte_ready at the clock edge.
REQ-008 wr_en  output  1  one-cycle instruction-memory write strobe.
REQ-009 wr_addr  output  32  byte address of the write; always word-aligned.
REQ-010 wr_data  output  32  instruction word to write.
REQ-011 core_rst  output  1  holds the processor in reset while high.
REQ-012 load_done  output  1  image loaded successfully; sticky until rst.
REQ-013 load_err  output  1  image rejected; sticky until rst.

Function
REQ-014 FSM states: IDLE, HDR, DATA, WRITE, CHK, DONE, ERR.
REQ-015 IDLE: byte_ready=0; advance to HDR unconditionally on the next edge.
REQ-016 HDR: byte_ready=1; accept 2 bytes, little-endian, forming the 16-bit word count N.
REQ-017 After the 2nd header byte: N=0 goes to DONE (or CHK when enabled); N>MAX_WORDS goes to ERR; otherwise go to DATA with word index 0.
REQ-018 DATA: byte_ready=1; accept 4 bytes per word, little-endian (first byte lands in bits [7:0]).
REQ-019 The 4th byte moves the FSM to WRITE, and the partial-byte counter wraps 3→0.
REQ-020 WRITE, exactly one cycle: byte_ready=0; wr_en=1; wr_addr=BASE_ADDR+4*index; wr_data=assembled word; index increments.
REQ-021 From WRITE: if index+1==N, go to DONE (or CHK when enabled); else return to DATA.
REQ-022 Write latency: wr_en asserts in the cycle immediately after the edge that accepts a word's 4th byte.
REQ-023 wr_en is 0 in every state except WRITE; wr_addr and wr_data hold their last values otherwise.
REQ-024 Inter-byte gaps (byte_valid low) of any length: the FSM holds state and no counter changes.
REQ-025 DONE: core_rst=0, load_done=1, byte_ready=0; terminal until rst.
REQ-026 ERR: core_rst=1, load_err=1, byte_ready=0; terminal until rst.
REQ-027 core_rst=1 in every state except DONE.
REQ-028 load_done and load_err are never both high.
REQ-029 Index counter width: clog2(MAX_WORDS+1) bits; the byte counter is 2 bits.
REQ-030 Address arithmetic is 32-bit and wraps modulo 2^32.

Reset
REQ-031 Asserting rst at any time, including mid-word or mid-header, forces IDLE asynchronously.
REQ-032 On reset the partial word, N, index and checksum are discarded.
REQ-033 Reset values: byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, core_rst=1, load_done=0, load_err=0.

Configuration
REQ-034 With macro IMEM_LOADER_CHECKSUM_EN defined: a CHK state follows the last word, or the header when N=0.
REQ-035 CHK (enabled only): byte_ready=1; accept 1 byte; if it equals the XOR of all header and data bytes go to DONE, else go to ERR.
REQ-036 Without IMEM_LOADER_CHECKSUM_EN: no CHK state, no checksum register, and no byte is consumed after the last word.

Structure
REQ-037 Shared package loader_pkg holds the state enum, HDR_BYTES=2 and BYTES_PER_WORD=4.
REQ-038 One sub-module, byte_packer: a little-endian 8-to-32 shift assembler with a byte counter and a word_full flag.

Verification
REQ-039 Image N=2, bytes 02 00 13 00 50 00 93 00 A0 00 -> wr_en at 0x0 with 0x00500013, then at 0x4 with 0x00A00093; then load_done=1 and core_rst=0.
REQ-040 Header N=0x0101 with MAX_WORDS=256 -> load_err=1, core_rst=1, wr_en never asserts, byte_ready=0 thereafter.
REQ-041 N=1 with byte_valid toggled 1/0 every cycle -> exactly one write, of 0xDEADBEEF at BASE_ADDR, from bytes EF BE AD DE.
REQ-042 rst pulsed after 2 data bytes of word 0 -> all outputs at reset values; a fresh N=1 image is then written correctly at BASE_ADDR.
REQ-043 Checksum enabled, image 01 00 11 22 33 44 with checksum byte 45 -> load_done=1; the same image with checksum byte 46 -> load_err=1, core_rst=1.
REQ-044 N=MAX_WORDS image -> the last write lands at BASE_ADDR+4*(MAX_WORDS-1), followed by DONE; with BASE_ADDR=0xFFFF_FFFC, word 1's address wraps to 0x0000_0000.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory image loader.
// The CHK state exists only when IMEM_LOADER_CHECKSUM_EN is defined.
package loader_pkg;

   localparam int unsigned HDR_BYTES      = 2;
   localparam int unsigned BYTES_PER_WORD = 4;

`ifdef IMEM_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {
      StIdle, StHdr, StData, StWrite, StDone, StErr, StChk
   } state_e;
`else
   typedef enum logic [2:0] {
      StIdle, StHdr, StData, StWrite, StDone, StErr
   } state_e;
`endif

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the image loader.
// master: image source / memory side; slave: the loader itself.
interface imem_loader_if;

   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;

   modport master (
      output byte_valid, byte_data,
      input  byte_ready, wr_en, wr_addr, wr_data
   );

   modport slave (
      input  byte_valid, byte_data,
      output byte_ready, wr_en, wr_addr, wr_data
   );

endinterface

// File: rtl/byte_packer.sv
// Little-endian 8-to-32 shift assembler. 'word' already includes the byte
// on byte_in, so it is the completed word in the cycle word_full is high.
module byte_packer
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_full
);

   logic [31:0] shift_q;
   logic [1:0]  cnt_q;

   // Newest byte enters at the top, so the first byte ends up in [7:0].
   assign word      = {byte_in, shift_q[31:8]};
   assign word_full = en && (cnt_q == 2'(BYTES_PER_WORD - 1));

   // Shift register and byte counter advance only on accepted bytes; counter wraps 3->0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else if (en) begin
         shift_q <= word;
         cnt_q   <= cnt_q + 2'd1;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: receives a length-prefixed byte image,
// writes it word by word from BASE_ADDR, then releases the core from reset.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
   import loader_pkg::*;
#(
   parameter int unsigned MAX_WORDS = 256,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic           clk,
   input  logic           rst,
   imem_loader_if.slave   bus,
   output logic           core_rst,
   output logic           load_done,
   output logic           load_err
);

   localparam int unsigned IdxW = $clog2(MAX_WORDS + 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam state_e AfterLast = StChk;
`else
   localparam state_e AfterLast = StDone;
`endif

   state_e          state_q, state_d;
   logic            hdr_cnt_q;
   logic [15:0]     n_q;
   logic [IdxW-1:0] idx_q;
   logic [31:0]     addr_q, data_q;

   logic            accept;
   logic            hdr_last;
   logic [15:0]     n_hdr;
   logic            last_word;
   logic            pack_en;
   logic            word_full;
   logic [31:0]     word;

   assign accept    = bus.byte_valid && bus.byte_ready;
   assign hdr_last  = (32'(hdr_cnt_q) == HDR_BYTES - 1);
   // Full word count as it will be once the current header byte lands.
   assign n_hdr     = {bus.byte_data, n_q[7:0]};
   assign last_word = (32'(idx_q) + 32'd1) == 32'(n_q);
   assign pack_en   = accept && (state_q == StData);

   byte_packer u_packer (
      .clk       (clk),
      .rst       (rst),
      .en        (pack_en),
      .byte_in   (bus.byte_data),
      .word      (word),
      .word_full (word_full)
   );

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] chk_q;
   logic       chk_ok;

   assign chk_ok = (bus.byte_data == chk_q);

   // Running XOR over every header and data byte.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chk_q <= '0;
      end else if (accept && (state_q != StChk)) begin
         chk_q <= chk_q ^ bus.byte_data;
      end
   end
`endif

   // Ready depends on state only, keeping the accept path free of loops.
   always_comb begin
      bus.byte_ready = 1'b0;
      unique case (state_q)
         StHdr, StData: bus.byte_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
         StChk:         bus.byte_ready = 1'b1;
`endif
         default:       bus.byte_ready = 1'b0;
      endcase
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: state_d = StHdr;
         StHdr: begin
            if (accept && hdr_last) begin
               if (n_hdr == 16'd0) begin
                  state_d = AfterLast;
               end else if (32'(n_hdr) > MAX_WORDS) begin
                  state_d = StErr;
               end else begin
                  state_d = StData;
               end
            end
         end
         StData: begin
            if (word_full) begin
               state_d = StWrite;
            end
         end
         StWrite: state_d = last_word ? AfterLast : StData;
`ifdef IMEM_LOADER_CHECKSUM_EN
         StChk: begin
            if (accept) begin
               state_d = chk_ok ? StDone : StErr;
            end
         end
`endif
         StDone:  state_d = StDone;
         StErr:   state_d = StErr;
         default: state_d = StIdle;
      endcase
   end

   // State, header, index and write-bus registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         hdr_cnt_q <= 1'b0;
         n_q       <= '0;
         idx_q     <= '0;
         addr_q    <= '0;
         data_q    <= '0;
      end else begin
         state_q <= state_d;
         if (accept && (state_q == StHdr)) begin
            hdr_cnt_q <= ~hdr_cnt_q;
            n_q       <= hdr_last ? n_hdr : {8'h00, bus.byte_data};
         end
         // Capture on the 4th byte so address/data are valid during WRITE and hold afterwards.
         if (word_full) begin
            data_q <= word;
            addr_q <= BASE_ADDR + (32'(idx_q) * BYTES_PER_WORD);
         end
         if (state_q == StWrite) begin
            idx_q <= idx_q + IdxW'(1);
         end
      end
   end

   assign bus.wr_en   = (state_q == StWrite);
   assign bus.wr_addr = addr_q;
   assign bus.wr_data = data_q;
   assign core_rst    = (state_q != StDone);
   assign load_done   = (state_q == StDone);
   assign load_err    = (state_q == StErr);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and random images checked
// against a byte-level model of the image format.
module tb_imem_loader;

   localparam int unsigned MAXW = 256;
   localparam logic [31:0] BASE = 32'hFFFF_FFFC;

   typedef logic [7:0] bq_t[$];

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic core_rst, load_done, load_err;

   imem_loader_if bus ();

   imem_loader #(
      .MAX_WORDS (MAXW),
      .BASE_ADDR (BASE)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .core_rst  (core_rst),
      .load_done (load_done),
      .load_err  (load_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] log_addr[$];
   logic [31:0] log_data[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge and record any write strobe seen there.
   task automatic tick();
      @(negedge clk);
      if (bus.wr_en === 1'b1) begin
         log_addr.push_back(bus.wr_addr);
         log_data.push_back(bus.wr_data);
      end
   endtask

   function automatic int gap_of(input int mode);
      if (mode == 1) return 1;
      if (mode == 2) return int'($urandom_range(0, 3));
      return 0;
   endfunction

   task automatic send_byte(input logic [7:0] b, input int gap);
      repeat (gap) begin
         bus.byte_valid = 1'b0;
         tick();
      end
      bus.byte_valid = 1'b1;
      bus.byte_data  = b;
      for (int t = 0; t < 50; t++) begin
         if (bus.byte_ready === 1'b1) begin
            tick();
            bus.byte_valid = 1'b0;
            return;
         end
         tick();
      end
      check("accept_timeout", 32'd0, 32'd1);
      bus.byte_valid = 1'b0;
   endtask

   task automatic do_reset();
      tick();
      #2;
      rst = 1'b1;
      bus.byte_valid = 1'b0;
      #1;
      check("rst_byte_ready", bus.byte_ready, 0);
      check("rst_wr_en", bus.wr_en, 0);
      check("rst_wr_addr", bus.wr_addr, 0);
      check("rst_wr_data", bus.wr_data, 0);
      check("rst_core_rst", core_rst, 1);
      check("rst_load_done", load_done, 0);
      check("rst_load_err", load_err, 0);
      tick();
      tick();
      rst = 1'b0;
      log_addr.delete();
      log_data.delete();
   endtask

   // Sends one image and checks writes and final status against the model.
   task automatic run_image(input bq_t img, input int gapmode, input bit cs_bad);
      int          n;
      bit          hdr_err;
      bit          exp_err;
      logic [7:0]  x;
      logic [31:0] w, a, oa, od;
      do_reset();
      n       = int'(img[0]) | (int'(img[1]) << 8);
      hdr_err = (n > int'(MAXW));
      exp_err = hdr_err;
      x       = 8'h00;
      for (int i = 0; i < 2; i++) begin
         send_byte(img[i], gap_of(gapmode));
         x ^= img[i];
      end
      if (!hdr_err) begin
         for (int i = 0; i < n * 4; i++) begin
            send_byte(img[2 + i], gap_of(gapmode));
            x ^= img[2 + i];
            if (i % 4 == 3) check("wr_latency", bus.wr_en, 1);
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         send_byte(cs_bad ? (x ^ 8'h03) : x, gap_of(gapmode));
         exp_err = cs_bad;
`endif
      end
      for (int t = 0; t < 20 && !(load_done || load_err); t++) tick();
      // Offer another byte: a finished loader must not take it.
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'hA5;
      repeat (4) tick();
      check("end_byte_ready", bus.byte_ready, 0);
      check("load_done", load_done, !exp_err);
      check("load_err", load_err, exp_err);
      check("core_rst", core_rst, exp_err);
      check("n_writes", log_addr.size(), hdr_err ? 0 : n);
      if (!hdr_err) begin
         for (int i = 0; i < n; i++) begin
            a  = BASE + 32'(4 * i);
            w  = {img[2 + 4*i + 3], img[2 + 4*i + 2], img[2 + 4*i + 1], img[2 + 4*i]};
            oa = (i < log_addr.size()) ? log_addr[i] : 'x;
            od = (i < log_data.size()) ? log_data[i] : 'x;
            check("wr_addr", oa, a);
            check("wr_data", od, w);
         end
      end
      bus.byte_valid = 1'b0;
   endtask

   initial begin
      bq_t img;
      int  n;
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'h00;

      // Two-word program.
      img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
      run_image(img, 0, 1'b0);

      // Abandon an image mid-word; the next reset must discard the partial state.
      do_reset();
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'h12, 0);
      send_byte(8'h34, 0);
      img = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      run_image(img, 1, 1'b0);

      // Word count above capacity.
      img = '{8'h01, 8'h01};
      run_image(img, 0, 1'b0);

      // Empty image.
      img = '{8'h00, 8'h00};
      run_image(img, 2, 1'b0);

      // Random small images with random gaps.
      for (int k = 0; k < 4; k++) begin
         n = int'($urandom_range(1, 6));
         img = {};
         img.push_back(8'(n));
         img.push_back(8'h00);
         for (int i = 0; i < n * 4; i++) img.push_back(8'($urandom));
         run_image(img, int'($urandom_range(0, 2)), 1'b0);
      end

      // Full-capacity image.
      img = {};
      img.push_back(8'(MAXW & 32'hFF));
      img.push_back(8'(MAXW >> 8));
      for (int i = 0; i < int'(MAXW) * 4; i++) img.push_back(8'($urandom));
      run_image(img, 0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
      img = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
      run_image(img, 0, 1'b0);
      run_image(img, 0, 1'b1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
